// File: rtl/async_fifo_rd_ctrl_if.sv
// Read-side bus bundle for async_fifo_rd_ctrl: FIFO read port plus the
// downstream valid/ready stream. The controller is the master.
interface async_fifo_rd_ctrl_if #(
  parameter int DSIZE = 8
);
  logic             rempty;
  logic [DSIZE-1:0] rdata;
  logic             rinc;
  logic             m_valid;
  logic [DSIZE-1:0] m_data;
  logic             m_ready;

  modport master (
    input  rempty, rdata, m_ready,
    output rinc, m_valid, m_data
  );

  modport slave (
    output rempty, rdata, m_ready,
    input  rinc, m_valid, m_data
  );
endinterface

// File: rtl/async_fifo_rd_ctrl.sv
// Read-domain FIFO consumer: pops the FIFO, captures rdata after RD_LAT cycles
// into a small output buffer, and streams it on valid/ready. Optional sequence
// checker enabled by `define ASYNC_FIFO_RD_CHECK_EN (adds o_err, o_err_cnt).
module async_fifo_rd_ctrl #(
  parameter int DSIZE      = 8,
  parameter int OBUF_DEPTH = 2,
  parameter int RD_LAT     = 1,
  parameter int CNT_W      = 16
) (
  input  logic                 i_rclk,
  input  logic                 i_rrst,
  input  logic                 i_en,
  async_fifo_rd_ctrl_if.master bus,
  output logic                 o_busy,
  output logic [CNT_W-1:0]     o_pop_cnt
`ifdef ASYNC_FIFO_RD_CHECK_EN
  ,
  output logic                 o_err,
  output logic [7:0]           o_err_cnt
`endif
);

  localparam int AW    = $clog2(OBUF_DEPTH);
  localparam int OCC_W = $clog2(OBUF_DEPTH) + 2;

  typedef enum logic [1:0] {IDLE, RUN, DRAIN} state_t;

  state_t             r_state, w_state_nxt;
  logic [RD_LAT-1:0]  r_vld_pipe;
  logic [DSIZE-1:0]   r_buf [OBUF_DEPTH];
  logic [AW-1:0]      r_wptr, r_rptr;
  logic [OCC_W-1:0]   r_occ;
  logic [CNT_W-1:0]   r_pop_cnt;

  logic               w_cap, w_rem, w_rinc;
  logic [OCC_W-1:0]   w_infl, w_room;

  assign w_cap = r_vld_pipe[RD_LAT-1];
  assign w_rem = (r_occ != '0) && bus.m_ready;

  always_comb begin
    w_infl = '0;
    for (int i = 0; i < RD_LAT; i++) w_infl = w_infl + OCC_W'(r_vld_pipe[i]);
  end

  // A word leaving this cycle frees its slot immediately; without this the
  // pop rule would stall every other cycle and lose back-to-back throughput.
  assign w_room = r_occ - OCC_W'(w_rem) + w_infl;
  assign w_rinc = (r_state == RUN) && !bus.rempty && (w_room < OCC_W'(OBUF_DEPTH));

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      IDLE:    if (i_en) w_state_nxt = RUN;
      RUN:     if (!i_en) w_state_nxt = DRAIN;
      DRAIN: begin
        if (i_en)                                  w_state_nxt = RUN;
        else if ((w_infl == '0) && (r_occ == '0))  w_state_nxt = IDLE;
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge i_rclk) begin
    if (i_rrst) begin
      r_state    <= IDLE;
      r_vld_pipe <= '0;
      r_wptr     <= '0;
      r_rptr     <= '0;
      r_occ      <= '0;
      r_pop_cnt  <= '0;
      for (int i = 0; i < OBUF_DEPTH; i++) r_buf[i] <= '0;
    end else begin
      r_state       <= w_state_nxt;
      r_vld_pipe[0] <= w_rinc;
      for (int i = 1; i < RD_LAT; i++) r_vld_pipe[i] <= r_vld_pipe[i-1];
      if (w_cap) begin
        r_buf[r_wptr] <= bus.rdata;
        r_wptr        <= r_wptr + AW'(1);
      end
      if (w_rem) r_rptr <= r_rptr + AW'(1);
      r_occ <= r_occ + OCC_W'(w_cap) - OCC_W'(w_rem);
      if (w_rinc) r_pop_cnt <= r_pop_cnt + CNT_W'(1);
    end
  end

  assign bus.rinc    = w_rinc;
  assign bus.m_valid = (r_occ != '0);
  assign bus.m_data  = r_buf[r_rptr];
  assign o_busy      = (r_state != IDLE);
  assign o_pop_cnt   = r_pop_cnt;

`ifdef ASYNC_FIFO_RD_CHECK_EN
  logic [DSIZE-1:0] r_exp;
  logic             r_err;
  logic [7:0]       r_err_cnt;

  // On a match rdata+1 equals r_exp+1, so both paths resync the same way.
  always_ff @(posedge i_rclk) begin
    if (i_rrst) begin
      r_exp     <= '0;
      r_err     <= 1'b0;
      r_err_cnt <= '0;
    end else if (w_cap) begin
      r_exp <= bus.rdata + DSIZE'(1);
      if (bus.rdata != r_exp) begin
        r_err <= 1'b1;
        if (r_err_cnt != 8'hFF) r_err_cnt <= r_err_cnt + 8'd1;
      end
    end
  end

  assign o_err     = r_err;
  assign o_err_cnt = r_err_cnt;
`endif

endmodule

// File: tb/tb_async_fifo_rd_ctrl.sv
// Bench for async_fifo_rd_ctrl: array-backed FIFO model, pop-order scoreboard,
// directed phases from the test plan plus a randomized en/m_ready/push phase.
module tb_async_fifo_rd_ctrl;
  localparam int DSIZE      = 8;
  localparam int OBUF_DEPTH = 2;
  localparam int RD_LAT     = 1;
  localparam int CNT_W      = 16;

  logic             rclk = 1'b0;
  logic             rrst = 1'b1;
  logic             en   = 1'b0;
  logic             busy;
  logic [CNT_W-1:0] pop_cnt;
`ifdef ASYNC_FIFO_RD_CHECK_EN
  logic             err;
  logic [7:0]       err_cnt;
`endif

  async_fifo_rd_ctrl_if #(.DSIZE(DSIZE)) bus ();

  async_fifo_rd_ctrl #(
    .DSIZE(DSIZE), .OBUF_DEPTH(OBUF_DEPTH), .RD_LAT(RD_LAT), .CNT_W(CNT_W)
  ) dut (
    .i_rclk   (rclk),
    .i_rrst   (rrst),
    .i_en     (en),
    .bus      (bus),
    .o_busy   (busy),
    .o_pop_cnt(pop_cnt)
`ifdef ASYNC_FIFO_RD_CHECK_EN
    ,
    .o_err    (err),
    .o_err_cnt(err_cnt)
`endif
  );

  always #5 rclk = ~rclk;

  logic [DSIZE-1:0] mem [0:4095];
  int               wr_ptr = 0;
  int               rd_ptr = 0;
  assign bus.rempty = (rd_ptr == wr_ptr);

  int               n_err = 0;
  int               n_chk = 0;
  int               ref_pops = 0;
  int               cyc = 0;
  logic [DSIZE-1:0] exp_q [$];
  bit               last_pop, last_acc, prev_stall;
  logic [DSIZE-1:0] prev_data;

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, act, exp);
    end
  endtask

  task automatic push(input logic [DSIZE-1:0] d);
    mem[wr_ptr[11:0]] = d;
    wr_ptr++;
  endtask

  // One clock: observe at negedge, advance the FIFO model just after posedge.
  task automatic tick();
    @(negedge rclk);
    last_pop = bus.rinc;
    last_acc = bus.m_valid && bus.m_ready;
    if (prev_stall && bus.m_valid) chk("hold_m_data", 32'(bus.m_data), 32'(prev_data));
    prev_stall = bus.m_valid && !bus.m_ready;
    prev_data  = bus.m_data;
    if (last_acc) begin
      if (exp_q.size() == 0) chk("spurious_word", 32'(1), 32'(0));
      else                   chk("m_data_order", 32'(bus.m_data), 32'(exp_q.pop_front()));
    end
    if (last_pop) begin
      chk("pop_when_empty", 32'(bus.rempty), 32'(0));
      exp_q.push_back(mem[rd_ptr[11:0]]);
      ref_pops++;
    end
    if (exp_q.size() > OBUF_DEPTH) chk("outstanding_bound", 32'(exp_q.size()), 32'(OBUF_DEPTH));
    @(posedge rclk);
    #1;
    cyc++;
    if (last_pop) begin
      bus.rdata = mem[rd_ptr[11:0]];
      rd_ptr++;
    end
  endtask

  initial begin
    int  first_pop, last_pc, first_acc, npop, nacc, acc_i;
    bit  seen;
    bit  busy_hist [8];

    bus.rdata   = '0;
    bus.m_ready = 1'b0;
    prev_stall  = 1'b0;
    en          = 1'b1;
    rrst        = 1'b1;
    for (int i = 0; i < 16; i++) push(DSIZE'(i));
    @(posedge rclk);
    #1;

    // reset held with en=1 and a non-empty FIFO
    repeat (2) begin
      chk("rst_rinc",    32'(bus.rinc),    32'(0));
      chk("rst_m_valid", 32'(bus.m_valid), 32'(0));
      chk("rst_m_data",  32'(bus.m_data),  32'(0));
      chk("rst_busy",    32'(busy),        32'(0));
      chk("rst_pop_cnt", 32'(pop_cnt),     32'(0));
      tick();
    end

    // streaming 0x00..0x0F
    rrst = 1'b0;
    bus.m_ready = 1'b1;
    first_pop = -1; last_pc = -1; first_acc = -1; npop = 0; nacc = 0;
    for (int i = 0; i < 30; i++) begin
      tick();
      if (last_pop) begin
        if (first_pop < 0) first_pop = cyc;
        last_pc = cyc;
        npop++;
      end
      if (last_acc) begin
        if (first_acc < 0) first_acc = cyc;
        nacc++;
      end
    end
    chk("stream_pops",    32'(npop),                32'(16));
    chk("stream_b2b",     32'(last_pc - first_pop), 32'(15));
    chk("stream_latency", 32'(first_acc - first_pop), 32'(2));
    chk("stream_words",   32'(nacc),                32'(16));
    chk("stream_pop_cnt", 32'(pop_cnt),             32'(16));

    // backpressure with 8 words queued
    bus.m_ready = 1'b0;
    for (int i = 0; i < 8; i++) push(DSIZE'(8'h20 + i));
    npop = 0;
    repeat (10) begin
      tick();
      npop += int'(last_pop);
    end
    chk("bp_pops",    32'(npop),        32'(OBUF_DEPTH));
    chk("bp_rinc",    32'(bus.rinc),    32'(0));
    chk("bp_m_valid", 32'(bus.m_valid), 32'(1));
    bus.m_ready = 1'b1;
    nacc = 0;
    repeat (20) begin
      tick();
      nacc += int'(last_acc);
    end
    chk("bp_words",  32'(nacc),         32'(8));
    chk("bp_all_out", 32'(exp_q.size()), 32'(0));
    chk("bp_empty",  32'(bus.rempty),   32'(1));

    // single word then empty
    push(8'hA5);
    npop = 0; nacc = 0;
    repeat (8) begin
      tick();
      npop += int'(last_pop);
      nacc += int'(last_acc);
    end
    chk("one_pop",      32'(npop),        32'(1));
    chk("one_word",     32'(nacc),        32'(1));
    chk("empty_rinc",   32'(bus.rinc),    32'(0));
    chk("empty_mvalid", 32'(bus.m_valid), 32'(0));

    // drain: drop en once streaming is in steady state
    for (int i = 0; i < 6; i++) push(DSIZE'(8'h40 + i));
    seen = 1'b0;
    for (int i = 0; i < 10 && !seen; i++) begin
      tick();
      seen = last_acc;
    end
    chk("drain_setup", 32'(seen), 32'(1));
    en = 1'b0;
    tick();
    chk("drain_outstanding", 32'(exp_q.size()), 32'(2));
    npop = 0; nacc = 0; acc_i = 0;
    for (int i = 0; i < 7; i++) begin
      tick();
      npop += int'(last_pop);
      if (last_acc) begin
        nacc++;
        acc_i = i;
      end
      busy_hist[i] = busy;
    end
    chk("drain_no_pop",   32'(npop),                32'(0));
    chk("drain_words",    32'(nacc),                32'(2));
    chk("drain_busy_low", 32'(busy_hist[acc_i + 1]), 32'(0));
    chk("idle_rinc",      32'(bus.rinc),            32'(0));

    // random en / m_ready / FIFO fill
    for (int i = 0; i < 400; i++) begin
      en          = ($urandom_range(7) != 0);
      bus.m_ready = 1'($urandom_range(1));
      if ($urandom_range(2) == 0) push(DSIZE'($urandom));
      tick();
    end
    en = 1'b1;
    bus.m_ready = 1'b1;
    repeat (20) tick();
    chk("rand_all_out", 32'(exp_q.size()), 32'(0));
    chk("rand_empty",   32'(bus.rempty),   32'(1));
    chk("rand_pop_cnt", 32'(pop_cnt),      32'(ref_pops) & 32'hFFFF);

`ifdef ASYNC_FIFO_RD_CHECK_EN
    // sequence checker: 0,1,2,5,6 gives exactly one error
    en = 1'b0;
    rrst = 1'b1;
    repeat (2) tick();
    rrst = 1'b0;
    chk("chk_err_rst",  32'(err),     32'(0));
    chk("chk_cnt_rst",  32'(err_cnt), 32'(0));
    push(8'd0); push(8'd1); push(8'd2); push(8'd5); push(8'd6);
    en = 1'b1;
    nacc = 0;
    repeat (14) begin
      tick();
      nacc += int'(last_acc);
    end
    chk("chk_words",   32'(nacc),    32'(5));
    chk("chk_err",     32'(err),     32'(1));
    chk("chk_err_cnt", 32'(err_cnt), 32'(1));
`endif

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end
endmodule
